// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the round-robin XOR service arbiter.
// Optional watchdog is enabled by defining XARB_TIMEOUT_EN.
package xor_arb_pkg;

    // FSM states, 2-bit encoding in transaction order.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_Y = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_W   = 16;

    // Index width for n requesters, never less than 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first set request bit searching upward
// from ptr+1 and wrapping; returns a one-hot grant and its index.
module rr_grant
    import xor_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N positions starting just after the last served requester.
    always_comb begin
        int s;
        logic [IW-1:0] j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            j = IW'(s);
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/xor_req_arbiter.sv
// Shares one 1-bit XOR service among NUM_REQ requesters, round-robin,
// one transaction in flight: IDLE -> ISSUE -> WAIT_Y -> RESP -> IDLE.
// Handshakes: a channel transfers when its enable and ready are both high
// in the same cycle; no enable here depends combinationally on a ready.
// Optional WAIT_Y watchdog with sticky err_timeout: define XARB_TIMEOUT_EN.
module xor_req_arbiter
    import xor_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_enable,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_enable,
    output logic               rsp_data,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic               srv_a_data,
    output logic               srv_a_enable,
    input  logic               srv_a_ready,
    output logic               srv_b_data,
    output logic               srv_b_enable,
    input  logic               srv_b_ready,
    input  logic               srv_y_data,
    input  logic               srv_y_enable,
    output logic               srv_y_ready,
    output logic               busy,
    output logic [1:0]         dbg_state
`ifdef XARB_TIMEOUT_EN
    ,
    output logic               err_timeout
`endif
);

    localparam int IW = clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_param_check
        $error("xor_req_arbiter: parameter out of range");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          a_q, a_d, b_q, b_d;
    logic          a_sent_q, a_sent_d, b_sent_q, b_sent_d;
    logic          rsp_data_q, rsp_data_d;
    logic          blocked;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;

`ifdef XARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 drain_q, drain_d;
    // A stale Y owed by a timed-out transaction must be drained before new grants.
    assign blocked     = drain_q;
    assign err_timeout = err_q;
`else
    assign blocked = 1'b0;
`endif

    rr_grant #(.N(NUM_REQ), .IW(IW)) u_rr_grant (
        .req   (req_enable & ~{NUM_REQ{blocked}}),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Outputs decoded from state flops only (req_ready also follows the live grant).
    always_comb begin
        req_ready    = (state_q == IDLE) ? grant : '0;
        srv_a_enable = (state_q == ISSUE) && !a_sent_q;
        srv_b_enable = (state_q == ISSUE) && !b_sent_q;
        srv_a_data   = srv_a_enable & a_q;
        srv_b_data   = srv_b_enable & b_q;
        srv_y_ready  = (state_q == WAIT_Y) || blocked;
        rsp_enable   = (state_q == RESP) ? (NUM_REQ'(1) << idx_q) : '0;
        rsp_data     = rsp_data_q;
        busy         = (state_q != IDLE);
        dbg_state    = state_q;
    end

    // Next-state and register updates for one transaction.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        a_sent_d   = a_sent_q;
        b_sent_d   = b_sent_q;
        rsp_data_d = rsp_data_q;
`ifdef XARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
        drain_d = drain_q;
        if (drain_q && srv_y_enable) drain_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    idx_d    = grant_idx;
                    a_d      = req_a[grant_idx];
                    b_d      = req_b[grant_idx];
                    a_sent_d = 1'b0;
                    b_sent_d = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                a_sent_d = a_sent_q | srv_a_ready;
                b_sent_d = b_sent_q | srv_b_ready;
                if (a_sent_d && b_sent_d) begin
                    state_d = WAIT_Y;
`ifdef XARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            WAIT_Y: begin
                if (srv_y_enable) begin
                    rsp_data_d = srv_y_data;
                    state_d    = RESP;
                end
`ifdef XARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d      = 1'b1;
                    rsp_data_d = 1'b0;
                    drain_d    = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready[idx_q]) begin
                    rr_ptr_d = idx_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            a_sent_q   <= 1'b0;
            b_sent_q   <= 1'b0;
            rsp_data_q <= 1'b0;
`ifdef XARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_sent_q   <= a_sent_d;
            b_sent_q   <= b_sent_d;
            rsp_data_q <= rsp_data_d;
`ifdef XARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drain_q <= drain_d;
`endif
        end
    end

endmodule

// File: tb/tb_xor_req_arbiter.sv
// Bench for xor_req_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (round-robin order, XOR of operands)
// and a behavioural FIFO-buffered XOR service.
module tb_xor_req_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req_enable, req_a, req_b, req_ready;
    logic [N-1:0] rsp_enable, rsp_ready;
    logic         rsp_data;
    logic         srv_a_data, srv_a_enable, srv_a_ready;
    logic         srv_b_data, srv_b_enable, srv_b_ready;
    logic         srv_y_data, srv_y_enable, srv_y_ready;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef XARB_TIMEOUT_EN
    logic         err_timeout;
`endif

    xor_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_enable   (req_enable),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .rsp_enable   (rsp_enable),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .srv_a_data   (srv_a_data),
        .srv_a_enable (srv_a_enable),
        .srv_a_ready  (srv_a_ready),
        .srv_b_data   (srv_b_data),
        .srv_b_enable (srv_b_enable),
        .srv_b_ready  (srv_b_ready),
        .srv_y_data   (srv_y_data),
        .srv_y_enable (srv_y_enable),
        .srv_y_ready  (srv_y_ready),
        .busy         (busy),
        .dbg_state    (dbg_state)
`ifdef XARB_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs, applied at each negedge.
    logic [N-1:0] k_req_en, k_a, k_b, k_rsp_ready;
    logic         k_a_rdy, k_b_rdy, k_y_go;
    bit           rand_mode;

    // Reference model state: entry = {idx[2:0], a, b}.
    logic [4:0] exp_q[$];
    bit         in_flight;
    int         last;
    bit         m_drain;
    bit         expect_to;
    bit         a_fifo[$], b_fifo[$], y_fifo[$];

    // Samples from the latest step.
    logic [N-1:0] s_req_ready, s_rsp_enable;
    logic         s_rsp_data, s_a_en, s_a_data, s_b_en, s_b_data, s_y_ready, s_busy;
    logic [1:0]   s_state;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first requesting index after the last served one.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (lst + k) % N;
            if (r[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_defaults();
        k_req_en    = '0;
        k_a         = '0;
        k_b         = '0;
        k_rsp_ready = '1;
        k_a_rdy     = 1'b1;
        k_b_rdy     = 1'b1;
        k_y_go      = 1'b1;
    endtask

    // One clock cycle: drive at negedge, sample, score, advance models.
    task automatic step();
        logic [N-1:0] eg;
        logic [4:0]   h;
        int           gi;
        @(negedge clk);
        if (rand_mode) begin
            k_req_en    = N'($urandom_range(0, (1 << N) - 1));
            k_a         = N'($urandom_range(0, (1 << N) - 1));
            k_b         = N'($urandom_range(0, (1 << N) - 1));
            k_rsp_ready = N'($urandom_range(0, (1 << N) - 1));
            k_a_rdy     = ($urandom_range(0, 3) != 0);
            k_b_rdy     = ($urandom_range(0, 3) != 0);
            k_y_go      = ($urandom_range(0, 3) != 0);
        end
        req_enable   = k_req_en;
        req_a        = k_a;
        req_b        = k_b;
        rsp_ready    = k_rsp_ready;
        srv_a_ready  = k_a_rdy;
        srv_b_ready  = k_b_rdy;
        srv_y_enable = (y_fifo.size() > 0) && k_y_go;
        srv_y_data   = (y_fifo.size() > 0) ? y_fifo[0] : 1'b0;
        #1;
        s_req_ready  = req_ready;
        s_rsp_enable = rsp_enable;
        s_rsp_data   = rsp_data;
        s_a_en       = srv_a_enable;
        s_a_data     = srv_a_data;
        s_b_en       = srv_b_enable;
        s_b_data     = srv_b_data;
        s_y_ready    = srv_y_ready;
        s_busy       = busy;
        s_state      = dbg_state;

        h = (exp_q.size() > 0) ? exp_q[0] : 5'd0;
        chk("busy", 32'(busy), 32'(in_flight));
        eg = (in_flight || m_drain) ? '0 : pick(req_enable, last);
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (srv_a_enable) begin
            chk("srv_a_in_flight", 32'(in_flight), 32'(1));
            chk("srv_a_data", 32'(srv_a_data), 32'(h[1]));
        end
        if (srv_b_enable) begin
            chk("srv_b_in_flight", 32'(in_flight), 32'(1));
            chk("srv_b_data", 32'(srv_b_data), 32'(h[0]));
        end
        if (expect_to && rsp_enable != '0) m_drain = 1'b1;
        if (rsp_enable != '0) begin
            chk("rsp_enable", 32'(rsp_enable), in_flight ? (32'(1) << h[4:2]) : 32'(0));
            chk("rsp_data", 32'(rsp_data), 32'(expect_to ? 1'b0 : (h[1] ^ h[0])));
        end

        if (eg != '0) begin
            gi = oh2idx(eg);
            exp_q.push_back({3'(gi), req_a[gi], req_b[gi]});
            in_flight = 1'b1;
        end
        if (srv_a_enable && srv_a_ready) a_fifo.push_back(srv_a_data);
        if (srv_b_enable && srv_b_ready) b_fifo.push_back(srv_b_data);
        if (srv_y_enable && srv_y_ready) begin
            void'(y_fifo.pop_front());
            m_drain = 1'b0;
        end
        if (in_flight && (rsp_enable & rsp_ready) != '0) begin
            void'(exp_q.pop_front());
            in_flight = 1'b0;
            last      = int'(h[4:2]);
        end
        while (a_fifo.size() > 0 && b_fifo.size() > 0)
            y_fifo.push_back(a_fifo.pop_front() ^ b_fifo.pop_front());
    endtask

    // Reset pulse: outputs must drop as soon as reset rises.
    task automatic do_reset();
        @(negedge clk);
        set_defaults();
        req_enable   = '0;
        req_a        = '0;
        req_b        = '0;
        rsp_ready    = '0;
        srv_a_ready  = 1'b0;
        srv_b_ready  = 1'b0;
        srv_y_enable = 1'b0;
        srv_y_data   = 1'b0;
        reset        = 1'b1;
        exp_q.delete();
        a_fifo.delete();
        b_fifo.delete();
        y_fifo.delete();
        in_flight = 1'b0;
        m_drain   = 1'b0;
        expect_to = 1'b0;
        last      = N - 1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_enable", 32'(rsp_enable), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_srv_en", 32'({srv_a_enable, srv_b_enable, srv_a_data, srv_b_data}), 32'(0));
        chk("rst_y_ready", 32'(srv_y_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Let the current transaction complete with a fully ready environment.
    task automatic run_idle();
        int c;
        set_defaults();
        c = 0;
        do begin
            step();
            c++;
        end while ((in_flight || s_busy) && c < 60);
        chk("idle_reached", 32'(in_flight || s_busy), 32'(0));
    endtask

    initial begin
        int ng;
        int c;
        rand_mode = 1'b0;
        set_defaults();
        do_reset();

        // 1: single request, minimum latency.
        k_req_en = 4'b0001; k_a = 4'b0001; k_b = 4'b0000;
        step();
        chk("t1_req_ready", 32'(s_req_ready), 32'(4'b0001));
        chk("t1_busy_c0", 32'(s_busy), 32'(0));
        k_req_en = '0;
        step();
        chk("t1_srv_en", 32'({s_a_en, s_b_en}), 32'(2'b11));
        chk("t1_srv_data", 32'({s_a_data, s_b_data}), 32'(2'b10));
        step();
        chk("t1_y_ready", 32'(s_y_ready), 32'(1));
        chk("t1_state_wait_y", 32'(s_state), 32'(2));
        step();
        chk("t1_rsp_enable", 32'(s_rsp_enable), 32'(4'b0001));
        chk("t1_rsp_data", 32'(s_rsp_data), 32'(1));
        step();
        chk("t1_idle_busy", 32'(s_busy), 32'(0));

        // 2: full contention, grants rotate 0,1,2,3,0.
        do_reset();
        k_req_en = '1; k_a = '1; k_b = '1;
        ng = 0;
        c  = 0;
        while (ng < 5 && c < 60) begin
            step();
            c++;
            if (s_req_ready != '0) begin
                chk("t2_grant", 32'(oh2idx(s_req_ready)), 32'(ng % N));
                ng++;
            end
        end
        chk("t2_grant_count", 32'(ng), 32'(5));
        run_idle();

        // 3: B channel stalls after A is accepted.
        do_reset();
        k_req_en = 4'b0010; k_a = 4'b0010; k_b = 4'b0010;
        step();
        chk("t3_req_ready", 32'(s_req_ready), 32'(4'b0010));
        k_req_en = '0;
        k_b_rdy  = 1'b0;
        step();
        chk("t3_issue_both", 32'({s_a_en, s_b_en}), 32'(2'b11));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_a_done_b_held", 32'({s_a_en, s_b_en}), 32'(2'b01));
            chk("t3_no_y_ready", 32'(s_y_ready), 32'(0));
        end
        k_b_rdy = 1'b1;
        step();
        chk("t3_b_last", 32'({s_b_en, s_y_ready}), 32'(2'b10));
        step();
        chk("t3_wait_y", 32'({s_b_en, s_y_ready}), 32'(2'b01));
        run_idle();

        // 4: response backpressure on requester 2; other rsp_ready ignored.
        do_reset();
        k_req_en = 4'b0100; k_a = 4'b0100; k_b = 4'b0000;
        k_rsp_ready = 4'b1011;
        step();
        k_req_en = 4'b1011;
        c = 0;
        do begin
            step();
            c++;
        end while (s_rsp_enable == '0 && c < 20);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk("t4_rsp_enable", 32'(s_rsp_enable), 32'(4'b0100));
            chk("t4_rsp_data", 32'(s_rsp_data), 32'(1));
            chk("t4_no_grant", 32'(s_req_ready), 32'(0));
        end
        k_rsp_ready = '1;
        step();
        step();
        chk("t4_next_grant", 32'(s_req_ready), 32'(4'b1000));
        run_idle();

        // 5: reset while waiting for Y.
        do_reset();
        k_req_en = 4'b0001; k_a = 4'b0001; k_b = 4'b0001;
        k_y_go = 1'b0;
        step();
        k_req_en = '0;
        c = 0;
        do begin
            step();
            c++;
        end while (!s_y_ready && c < 10);
        chk("t5_in_wait_y", 32'(s_y_ready), 32'(1));
        do_reset();
        k_req_en = '1; k_a = 4'b0101;
        step();
        chk("t5_first_grant", 32'(s_req_ready), 32'(4'b0001));
        run_idle();

`ifdef XARB_TIMEOUT_EN
        // 6: Y withheld past the watchdog, then drained before the next grant.
        do_reset();
        expect_to = 1'b1;
        k_req_en = 4'b0001; k_a = 4'b0001; k_b = 4'b0000;
        k_y_go = 1'b0;
        step();
        k_req_en = '0;
        c = 0;
        do begin
            step();
            c++;
        end while (s_rsp_enable == '0 && c < 100);
        chk("t6_timeout_cycle", 32'(c), 32'(66));
        chk("t6_err_timeout", 32'(err_timeout), 32'(1));
        chk("t6_rsp_data", 32'(s_rsp_data), 32'(0));
        expect_to = 1'b0;
        k_req_en  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_blocked", 32'(s_req_ready), 32'(0));
        end
        k_y_go = 1'b1;
        step();
        step();
        chk("t6_regrant", 32'(s_req_ready), 32'(4'b0001));
        run_idle();
        chk("t6_err_sticky", 32'(err_timeout), 32'(1));
`endif

        // Randomized traffic against the model.
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) step();
        rand_mode = 1'b0;
        run_idle();
        chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
